nivel_comida_ctrl: RTL and testbench

NIVEL_COMIDA_CTRL -- requirements
Module: nivel_comida_ctrl

---
 rtl/nivel_comida_ctrl.sv | 163 ++++++++++++++++
 tb/tb_nivel_comida_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/nivel_comida_ctrl.sv
// Food/health level controller for the virtual pet: debounced feed/medicine buttons,
// round-robin arbitration, timed actions with cooldown, and periodic hunger decay.
module nivel_comida_ctrl #(
   parameter int unsigned TICKS_HAMBRE   = 50_000_000,
   parameter int unsigned TICKS_COMER    = 25_000_000,
   parameter int unsigned TICKS_MEDICINA = 25_000_000,
   parameter int unsigned TICKS_BLOQUEO  = 50_000_000,
   parameter int unsigned DEBOUNCE       = 500_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       Boton_Comida,
   input  logic       Boton_Medicina,
   input  logic       Activo_Comida,
   input  logic       Activo_Medicina,
   output logic [1:0] Nivel_Comida,
   output logic [1:0] Nivel_Salud,
   output logic       Comiendo,
   output logic       Medicando,
   output logic [1:0] Estado_Ctrl
);

   localparam int unsigned ACT_MAX1 = (TICKS_COMER > TICKS_MEDICINA) ? TICKS_COMER : TICKS_MEDICINA;
   localparam int unsigned ACT_MAX  = (ACT_MAX1 > TICKS_BLOQUEO) ? ACT_MAX1 : TICKS_BLOQUEO;
   localparam int ACT_W = $clog2(ACT_MAX + 1);
   localparam int HAM_W = $clog2(TICKS_HAMBRE + 1);
   localparam int DEB_W = $clog2(DEBOUNCE + 1);

   typedef enum logic [1:0] {
      IDLE      = 2'b00,
      COMIENDO  = 2'b01,
      MEDICANDO = 2'b10,
      BLOQUEO   = 2'b11
   } state_t;

   state_t             state_q, state_d;
   logic [1:0]         syncC_q, syncC_d, syncM_q, syncM_d;
   logic [DEB_W-1:0]   debC_q, debC_d, debM_q, debM_d;
   logic [ACT_W-1:0]   actCnt_q, actCnt_d;
   logic [HAM_W-1:0]   decay_q, decay_d;
   logic [1:0]         food_q, food_d, health_q, health_d;
   logic               rrMed_q, rrMed_d;
   logic               comiendo_q, comiendo_d, medicando_q, medicando_d;

   logic               pulseC, pulseM, qualC, qualM, grantC, grantM;
   logic               foodInc, healthInc, decayWrap;
   logic [2:0]         healthSum;

   always_comb begin
      syncC_d = {syncC_q[0], Boton_Comida};
      syncM_d = {syncM_q[0], Boton_Medicina};

      // The counter saturates at DEBOUNCE so a long press yields exactly one pulse.
      pulseC = syncC_q[1] && (debC_q == DEB_W'(DEBOUNCE - 1));
      pulseM = syncM_q[1] && (debM_q == DEB_W'(DEBOUNCE - 1));
      if (!syncC_q[1])                       debC_d = '0;
      else if (debC_q == DEB_W'(DEBOUNCE))   debC_d = debC_q;
      else                                   debC_d = debC_q + 1'b1;
      if (!syncM_q[1])                       debM_d = '0;
      else if (debM_q == DEB_W'(DEBOUNCE))   debM_d = debM_q;
      else                                   debM_d = debM_q + 1'b1;

      qualC  = pulseC && Activo_Comida;
      qualM  = pulseM && Activo_Medicina;
      grantC = qualC && (!qualM || !rrMed_q);
      grantM = qualM && (!qualC || rrMed_q);

      state_d   = state_q;
      actCnt_d  = actCnt_q;
      rrMed_d   = rrMed_q;
      foodInc   = 1'b0;
      healthInc = 1'b0;
      unique case (state_q)
         IDLE: begin
            actCnt_d = '0;
            if (qualC && qualM) rrMed_d = ~rrMed_q;
            if (grantC)      state_d = COMIENDO;
            else if (grantM) state_d = MEDICANDO;
         end
         COMIENDO: begin
            if (actCnt_q == ACT_W'(TICKS_COMER - 1)) begin
               state_d  = BLOQUEO;
               actCnt_d = '0;
               foodInc  = 1'b1;
            end else begin
               actCnt_d = actCnt_q + 1'b1;
            end
         end
         MEDICANDO: begin
            if (actCnt_q == ACT_W'(TICKS_MEDICINA - 1)) begin
               state_d   = BLOQUEO;
               actCnt_d  = '0;
               healthInc = 1'b1;
            end else begin
               actCnt_d = actCnt_q + 1'b1;
            end
         end
         BLOQUEO: begin
            if (actCnt_q == ACT_W'(TICKS_BLOQUEO - 1)) begin
               state_d  = IDLE;
               actCnt_d = '0;
            end else begin
               actCnt_d = actCnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Hunger decay is frozen while eating and restarts from zero afterwards.
      decayWrap = (state_q != COMIENDO) && (decay_q == HAM_W'(TICKS_HAMBRE - 1));
      if (state_q == COMIENDO || decayWrap) decay_d = '0;
      else                                  decay_d = decay_q + 1'b1;

      food_d = food_q;
      if (foodInc && food_q != 2'd3)                   food_d = food_q + 1'b1;
      else if (decayWrap && food_q != 2'd0)            food_d = food_q - 1'b1;

      // Medicine and starvation in one cycle: add first, subtract, then clamp.
      healthSum = {1'b0, health_q} + {2'b00, healthInc};
      if (decayWrap && food_q == 2'd0 && healthSum != 3'd0) healthSum = healthSum - 1'b1;
      health_d = (healthSum > 3'd3) ? 2'd3 : healthSum[1:0];

      comiendo_d  = (state_d == COMIENDO);
      medicando_d = (state_d == MEDICANDO);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         syncC_q     <= '0;
         syncM_q     <= '0;
         debC_q      <= '0;
         debM_q      <= '0;
         actCnt_q    <= '0;
         decay_q     <= '0;
         food_q      <= 2'd3;
         health_q    <= 2'd3;
         rrMed_q     <= 1'b0;
         comiendo_q  <= 1'b0;
         medicando_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         syncC_q     <= syncC_d;
         syncM_q     <= syncM_d;
         debC_q      <= debC_d;
         debM_q      <= debM_d;
         actCnt_q    <= actCnt_d;
         decay_q     <= decay_d;
         food_q      <= food_d;
         health_q    <= health_d;
         rrMed_q     <= rrMed_d;
         comiendo_q  <= comiendo_d;
         medicando_q <= medicando_d;
      end
   end

   assign Nivel_Comida = food_q;
   assign Nivel_Salud  = health_q;
   assign Comiendo     = comiendo_q;
   assign Medicando    = medicando_q;
   assign Estado_Ctrl  = state_q;

endmodule

// File: tb/tb_nivel_comida_ctrl.sv
// Bench for nivel_comida_ctrl: directed scenarios plus randomized presses, all checked
// every cycle against a countdown-style behavioural model of the pet's food/health rules.
module tb_nivel_comida_ctrl;

   localparam int T_HAM = 8;
   localparam int T_COM = 4;
   localparam int T_MED = 4;
   localparam int T_BLQ = 4;
   localparam int T_DEB = 3;

   logic       clk;
   logic       reset;
   logic       botonComida, botonMedicina, activoComida, activoMedicina;
   logic [1:0] nivelComida, nivelSalud, estadoCtrl;
   logic       comiendo, medicando;

   int passCount;
   int checkCount;

   // Model state: levels, current activity (0 idle, 1 eat, 2 medicine, 3 cooldown),
   // cycles left in that activity, cycles since last hunger step, button delay lines.
   int mFood, mHealth, mMode, mRemain, mHunger, mRunC, mRunM;
   bit mFoodFirst;
   int lineC[$];
   int lineM[$];

   nivel_comida_ctrl #(
      .TICKS_HAMBRE(T_HAM), .TICKS_COMER(T_COM), .TICKS_MEDICINA(T_MED),
      .TICKS_BLOQUEO(T_BLQ), .DEBOUNCE(T_DEB)
   ) dut (
      .clk(clk), .reset(reset),
      .Boton_Comida(botonComida), .Boton_Medicina(botonMedicina),
      .Activo_Comida(activoComida), .Activo_Medicina(activoMedicina),
      .Nivel_Comida(nivelComida), .Nivel_Salud(nivelSalud),
      .Comiendo(comiendo), .Medicando(medicando), .Estado_Ctrl(estadoCtrl)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int clamp3(input int v);
      return (v < 0) ? 0 : ((v > 3) ? 3 : v);
   endfunction

   task automatic modelReset();
      mFood = 3; mHealth = 3; mMode = 0; mRemain = 0; mHunger = 0;
      mRunC = 0; mRunM = 0; mFoodFirst = 1'b1;
      lineC = '{0, 0};
      lineM = '{0, 0};
   endtask

   task automatic modelStep(input int bc, input int bm, input int ac, input int am);
      int lvlC, lvlM, dFood, dHealth;
      bit pulseC, pulseM, wantC, wantM, wrap;
      lvlC = lineC[0]; void'(lineC.pop_front()); lineC.push_back(bc);
      lvlM = lineM[0]; void'(lineM.pop_front()); lineM.push_back(bm);
      mRunC  = lvlC ? mRunC + 1 : 0;
      mRunM  = lvlM ? mRunM + 1 : 0;
      pulseC = (mRunC == T_DEB);
      pulseM = (mRunM == T_DEB);
      dFood = 0; dHealth = 0; wrap = 0;
      if (mMode == 1) mHunger = 0;
      else begin
         mHunger++;
         if (mHunger == T_HAM) begin wrap = 1; mHunger = 0; end
      end
      case (mMode)
         0: begin
            wantC = pulseC && (ac != 0);
            wantM = pulseM && (am != 0);
            if (wantC && wantM) begin
               mMode = mFoodFirst ? 1 : 2;
               mFoodFirst = !mFoodFirst;
            end else if (wantC) mMode = 1;
            else if (wantM)     mMode = 2;
            mRemain = (mMode == 1) ? T_COM : T_MED;
         end
         1, 2: begin
            mRemain--;
            if (mRemain == 0) begin
               if (mMode == 1) dFood = 1; else dHealth = 1;
               mMode = 3; mRemain = T_BLQ;
            end
         end
         default: begin
            mRemain--;
            if (mRemain == 0) mMode = 0;
         end
      endcase
      if (wrap) begin
         if (mFood == 0) dHealth -= 1; else dFood -= 1;
      end
      mFood   = clamp3(mFood + dFood);
      mHealth = clamp3(mHealth + dHealth);
   endtask

   task automatic checkValue(input string tag, input int observed, input int expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
   endtask

   task automatic checkOutput();
      checkValue("nivel_comida", int'(nivelComida), mFood);
      checkValue("nivel_salud",  int'(nivelSalud),  mHealth);
      checkValue("estado_ctrl",  int'(estadoCtrl),  mMode);
      checkValue("comiendo",     int'(comiendo),    (mMode == 1) ? 1 : 0);
      checkValue("medicando",    int'(medicando),   (mMode == 2) ? 1 : 0);
   endtask

   // One clock cycle: drive inputs, advance the model, then compare after the edge.
   task automatic applyStimulus(input int bc, input int bm, input int ac, input int am);
      botonComida    = bc[0];
      botonMedicina  = bm[0];
      activoComida   = ac[0];
      activoMedicina = am[0];
      modelStep(bc, bm, ac, am);
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   task automatic doReset(input string tag);
      botonComida = 1'b0; botonMedicina = 1'b0;
      reset = 1'b0;
      #2;
      modelReset();
      checkValue({tag, "_food"},   int'(nivelComida), 3);
      checkValue({tag, "_health"}, int'(nivelSalud),  3);
      checkValue({tag, "_estado"}, int'(estadoCtrl),  0);
      checkValue({tag, "_com"},    int'(comiendo),    0);
      checkValue({tag, "_med"},    int'(medicando),   0);
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      int comCycles, medCycles, busyCycles, holdC, holdM, bc, bm, ac, am;
      passCount = 0; checkCount = 0;
      botonComida = 0; botonMedicina = 0; activoComida = 0; activoMedicina = 0;
      reset = 1'b1;
      #3;
      doReset("reset_init");

      $display("[TB] hunger decay with no buttons");
      for (int i = 1; i <= 40; i++) begin
         applyStimulus(0, 0, 1, 1);
         if (i == 8)  checkValue("decay_food_8",    int'(nivelComida), 2);
         if (i == 16) checkValue("decay_food_16",   int'(nivelComida), 1);
         if (i == 24) checkValue("decay_food_24",   int'(nivelComida), 0);
         if (i == 32) checkValue("decay_health_32", int'(nivelSalud),  2);
         if (i == 40) checkValue("decay_health_40", int'(nivelSalud),  1);
      end

      $display("[TB] single feed from level 1");
      doReset("reset_feed");
      for (int i = 1; i <= 16; i++) applyStimulus(0, 0, 1, 1);
      checkValue("feed_start_food", int'(nivelComida), 1);
      comCycles = 0;
      for (int i = 1; i <= 16; i++) begin
         applyStimulus((i <= 10) ? 1 : 0, 0, 1, 0);
         if (comiendo) comCycles++;
      end
      checkValue("feed_comiendo_cycles", comCycles, 4);
      checkValue("feed_end_food", int'(nivelComida), 2);
      checkValue("feed_end_estado", int'(estadoCtrl), 0);

      $display("[TB] simultaneous requests alternate");
      doReset("reset_rr");
      for (int round = 0; round < 2; round++) begin
         comCycles = 0; medCycles = 0;
         for (int i = 1; i <= 22; i++) begin
            applyStimulus((i <= 6) ? 1 : 0, (i <= 6) ? 1 : 0, 1, 1);
            if (comiendo)  comCycles++;
            if (medicando) medCycles++;
         end
         checkValue("rr_com_cycles", comCycles, (round == 0) ? 4 : 0);
         checkValue("rr_med_cycles", medCycles, (round == 0) ? 0 : 4);
      end

      $display("[TB] disabled request and press during cooldown");
      doReset("reset_drop");
      busyCycles = 0;
      for (int i = 1; i <= 10; i++) begin
         applyStimulus((i <= 8) ? 1 : 0, 0, 0, 1);
         if (estadoCtrl != 2'b00) busyCycles++;
      end
      checkValue("disabled_busy_cycles", busyCycles, 0);
      comCycles = 0; medCycles = 0;
      for (int i = 1; i <= 20; i++) begin
         applyStimulus((i >= 7 && i <= 15) ? 1 : 0, (i <= 4) ? 1 : 0, 1, 1);
         if (comiendo)  comCycles++;
         if (medicando) medCycles++;
      end
      checkValue("cooldown_com_cycles", comCycles, 0);
      checkValue("cooldown_med_cycles", medCycles, 4);

      $display("[TB] reset during feeding");
      doReset("reset_abort_pre");
      for (int i = 1; i <= 16; i++) applyStimulus(0, 0, 1, 1);
      for (int i = 1; i <= 6; i++)  applyStimulus(1, 0, 1, 0);
      checkValue("abort_comiendo_before", int'(comiendo), 1);
      checkValue("abort_food_before", int'(nivelComida), 1);
      doReset("reset_abort");
      for (int i = 1; i <= 6; i++) applyStimulus(0, 0, 1, 1);

      $display("[TB] bouncing button");
      doReset("reset_bounce");
      busyCycles = 0;
      for (int i = 1; i <= 16; i++) begin
         applyStimulus((i <= 12) ? (i % 2) : 0, (i <= 12) ? ((i + 1) % 2) : 0, 1, 1);
         if (estadoCtrl != 2'b00) busyCycles++;
      end
      checkValue("bounce_busy_cycles", busyCycles, 0);

      $display("[TB] randomized presses");
      holdC = 0; holdM = 0; bc = 0; bm = 0; ac = 1; am = 1;
      for (int i = 0; i < 600; i++) begin
         if (holdC == 0) begin bc = $urandom_range(0, 1); holdC = $urandom_range(1, 9); end
         if (holdM == 0) begin bm = $urandom_range(0, 1); holdM = $urandom_range(1, 9); end
         holdC--; holdM--;
         if ($urandom_range(0, 7) == 0) ac = $urandom_range(0, 1);
         if ($urandom_range(0, 7) == 0) am = $urandom_range(0, 1);
         if ($urandom_range(0, 149) == 0) doReset("reset_random");
         applyStimulus(bc, bm, ac, am);
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
